// File: rtl/gate_pkg.sv
// Shared opcode encodings, FSM state type and opcode helpers for the gate reduce unit.
package gate_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_NAND = 3'b011;
  localparam op_t OP_NOR  = 3'b100;
  localparam op_t OP_XNOR = 3'b101;
  localparam op_t OP_RSV6 = 3'b110;
  localparam op_t OP_RSV7 = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Opcodes 110/111 carry no gate of their own.
  function automatic logic is_reserved(input op_t op);
    return (op == OP_RSV6) || (op == OP_RSV7);
  endfunction

  // Inverting gates are reduced with their base gate and inverted once at the end.
  function automatic logic is_invert(input op_t op);
    return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
  endfunction

  // Gate used for the running reduction; reserved codes fall back to OR.
  function automatic op_t base_op(input op_t op);
    op_t r;
    case (op)
      OP_AND:  r = OP_AND;
      OP_OR:   r = OP_OR;
      OP_XOR:  r = OP_XOR;
      OP_NAND: r = OP_AND;
      OP_NOR:  r = OP_OR;
      OP_XNOR: r = OP_XOR;
      default: r = OP_OR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_alu.sv
// Combinational W-bit two-operand gate; reserved opcodes behave as OR.
module gate_alu
  import gate_pkg::*;
#(
  parameter int W = 8
) (
  input  op_t          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  // Select the bitwise function of the two operands.
  always_comb begin
    y_o = '0;
    case (op_i)
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_NAND: y_o = ~(a_i & b_i);
      OP_NOR:  y_o = ~(a_i | b_i);
      OP_XNOR: y_o = ~(a_i ^ b_i);
      default: y_o = a_i | b_i;
    endcase
  end

endmodule

// File: rtl/gate_reduce_unit.sv
// Streaming multi-operand bitwise gate: reduces a packet of words and holds
// the registered result, beat count and error flag until it is consumed.
module gate_reduce_unit
  import gate_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [W-1:0]     acc_q, acc_d;
  op_t              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_err_q, out_err_d;

  logic             accept_s;
  logic             first_s;
  logic [W-1:0]     step_y_s;
  logic [W-1:0]     acc_nxt_s;
  op_t              eff_op_s;
  op_t              fin_op_s;
  logic [W-1:0]     res_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             err_nxt_s;

  assign accept_s = in_valid && in_ready;
  assign first_s  = (state_q == IDLE);

  // Accumulate step: fold the incoming word into the running value with the base gate.
  gate_alu #(.W(W)) u_step_alu (
    .op_i (base_op(op_q)),
    .a_i  (acc_q),
    .b_i  (in_data),
    .y_o  (step_y_s)
  );

  assign acc_nxt_s = first_s ? in_data : step_y_s;
  assign eff_op_s  = first_s ? op_t'(in_op) : op_q;

  // Final stage: x&x passes the value, ~(x&x) applies the single output inversion.
  assign fin_op_s = is_invert(eff_op_s) ? OP_NAND : OP_AND;

  gate_alu #(.W(W)) u_fin_alu (
    .op_i (fin_op_s),
    .a_i  (acc_nxt_s),
    .b_i  (acc_nxt_s),
    .y_o  (res_s)
  );

  assign cnt_nxt_s = first_s ? CNT_ONE :
                     ((cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE));
  assign err_nxt_s = first_s ? is_reserved(op_t'(in_op)) :
                     (err_q | (cnt_q == CNT_MAX));

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      op_q        <= OP_AND;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  // Next-state logic: collect beats until the last one, then hold until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = in_last ? HOLD : ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (accept_s && in_last) begin
          state_d = HOLD;
        end else begin
          state_d = ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: update on accepted beats, capture the result on the last beat.
  always_comb begin
    acc_d       = acc_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;
    if (accept_s) begin
      acc_d = acc_nxt_s;
      op_d  = eff_op_s;
      cnt_d = cnt_nxt_s;
      err_d = err_nxt_s;
      if (in_last) begin
        out_valid_d = 1'b1;
        out_data_d  = res_s;
        out_count_d = cnt_nxt_s;
        out_err_d   = err_nxt_s;
      end else begin
        out_valid_d = out_valid_q;
      end
    end else if ((state_q == HOLD) && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Outputs: input side is open whenever no result is being held.
  always_comb begin
    if (state_q == HOLD) begin
      in_ready = 1'b0;
    end else begin
      in_ready = 1'b1;
    end
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_count = out_count_q;
    out_err   = out_err_q;
  end

endmodule

// File: tb/tb_gate_reduce_unit.sv
// Bench for gate_reduce_unit: vector table of packets plus hand-written
// sequences for gaps, backpressure, saturation and mid-packet reset.
module tb_gate_reduce_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_count;
  logic       out_err;

  gate_reduce_unit #(.W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      op;
    int              n;
    logic [3:0][7:0] d;
    logic [7:0]      ed;
    logic [3:0]      ec;
    logic            ee;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [3:0] c;
    logic       e;
  } exp_t;

  vec_t tbl[9];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [3:0] c, input logic e);
    exp_t x;
    x.d = d; x.c = c; x.e = e;
    sb.push_back(x);
  endtask

  // Offer one beat (at negedge) and return at the negedge after it was accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic [2:0] op);
    int t;
    t = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_op = op;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("beat_accept_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for a result, compare it against the scoreboard and consume it.
  task automatic get_result(input string name);
    exp_t e;
    int   t;
    t = 0;
    out_ready = 1'b1;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      check({name, "_valid_timeout"}, {31'd0, out_valid}, 32'd1);
    end else if (sb.size() == 0) begin
      n_checks++; n_err++;
      $display("FAIL %s_unexpected: result with empty scoreboard", name);
    end else begin
      e = sb.pop_front();
      check({name, "_data"},  {24'd0, out_data},  {24'd0, e.d});
      check({name, "_count"}, {28'd0, out_count}, {28'd0, e.c});
      check({name, "_err"},   {31'd0, out_err},   {31'd0, e.e});
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{3'b000, 3, {8'h00, 8'h3C, 8'hF0, 8'hFF}, 8'h30, 4'd3, 1'b0};
    tbl[1] = '{3'b011, 2, {8'h00, 8'h00, 8'h0F, 8'hFF}, 8'hF0, 4'd2, 1'b0};
    tbl[2] = '{3'b101, 1, {8'h00, 8'h00, 8'h00, 8'hA5}, 8'h5A, 4'd1, 1'b0};
    tbl[3] = '{3'b111, 2, {8'h00, 8'h00, 8'h30, 8'h0C}, 8'h3C, 4'd2, 1'b1};
    tbl[4] = '{3'b100, 2, {8'h00, 8'h00, 8'h02, 8'h01}, 8'hFC, 4'd2, 1'b0};
    tbl[5] = '{3'b001, 4, {8'h01, 8'h40, 8'h20, 8'h10}, 8'h71, 4'd4, 1'b0};
    tbl[6] = '{3'b010, 1, {8'h00, 8'h00, 8'h00, 8'h3C}, 8'h3C, 4'd1, 1'b0};
    tbl[7] = '{3'b110, 1, {8'h00, 8'h00, 8'h00, 8'h55}, 8'h55, 4'd1, 1'b1};
    tbl[8] = '{3'b101, 2, {8'h00, 8'h00, 8'h33, 8'h0F}, 8'hC3, 4'd2, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    in_op = 3'b000; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_data",  {24'd0, out_data},  32'd0);
    check("rst_out_count", {28'd0, out_count}, 32'd0);
    check("rst_out_err",   {31'd0, out_err},   32'd0);

    // Table-driven packets.
    for (int i = 0; i < 9; i++) begin
      for (int b = 0; b < tbl[i].n; b++) begin
        send_beat(tbl[i].d[b], (b == tbl[i].n - 1), tbl[i].op);
        if (b == tbl[i].n - 1)
          check($sformatf("vec%0d_latency", i), {31'd0, out_valid}, 32'd1);
        else
          check($sformatf("vec%0d_busy", i), {31'd0, out_valid}, 32'd0);
      end
      push_exp(tbl[i].ed, tbl[i].ec, tbl[i].ee);
      get_result($sformatf("vec%0d", i));
    end

    // XOR with idle gaps; in_op changed to OR after the first beat must be ignored.
    send_beat(8'h01, 1'b0, 3'b010);
    repeat (2) @(negedge clk);
    send_beat(8'h02, 1'b0, 3'b001);
    @(negedge clk);
    check("gap_no_valid", {31'd0, out_valid}, 32'd0);
    send_beat(8'h04, 1'b0, 3'b001);
    repeat (3) @(negedge clk);
    send_beat(8'h01, 1'b1, 3'b001);
    push_exp(8'h06, 4'd4, 1'b0);
    get_result("xor_gaps");

    // Backpressure: held result stable, offered beat not consumed until release.
    send_beat(8'h5A, 1'b1, 3'b000);
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b1; in_op = 3'b001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d_data", k),  {24'd0, out_data},  32'h5A);
      check($sformatf("bp%0d_ready", k), {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready},  32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    push_exp(8'h11, 4'd1, 1'b0);
    get_result("bp_next");

    // Count saturation: 17 OR beats of 8'h01.
    for (int b = 0; b < 17; b++) send_beat(8'h01, (b == 16), 3'b001);
    push_exp(8'h01, 4'd15, 1'b1);
    get_result("sat17");

    // Reset in the middle of a packet discards it.
    send_beat(8'hFF, 1'b0, 3'b000);
    send_beat(8'hFF, 1'b0, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready},  32'd1);
    check("mid_rst_count", {28'd0, out_count}, 32'd0);
    send_beat(8'h80, 1'b1, 3'b001);
    push_exp(8'h80, 4'd1, 1'b0);
    get_result("after_rst");

    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
